// File: rtl/red_pitaya_pkg.sv
// Shared definitions for the slow-analog PWM path: default widths, duty type
// and the signed-to-offset-binary conversion used on the DSP routing data.
package red_pitaya_pkg;

   localparam int unsigned PWM_DAT_BITS    = 14;
   localparam int unsigned PWM_CCW_BITS    = 8;
   localparam int unsigned PWM_DITHER_BITS = 6;

   // Duty in high cycles per period, 0 .. 2**PWM_CCW_BITS inclusive.
   typedef logic [PWM_CCW_BITS:0] pwm_duty_t;

   // 2**13: adding it to a 14-bit two's-complement value is an MSB flip.
   localparam logic [PWM_DAT_BITS-1:0] PWM_OFFSET = 14'h2000;

   // Signed two's-complement sample to unsigned offset binary.
   function automatic logic [PWM_DAT_BITS-1:0] pwm_offset_conv(input logic [PWM_DAT_BITS-1:0] dat);
      return dat ^ PWM_OFFSET;
   endfunction

endpackage

// File: rtl/red_pitaya_pwm_sd_acc.sv
// First-order sigma-delta accumulator for the PWM dither LSBs.
// carry is the overflow of acc + lo and is meaningful in the load cycle.
module red_pitaya_pwm_sd_acc
   import red_pitaya_pkg::*;
#(
   parameter int unsigned W = PWM_DITHER_BITS
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic [W-1:0] lo,
   input  logic         load,
   input  logic         clear,
   output logic         carry
);

   logic [W-1:0] acc_r;
   logic [W:0]   sum_s;

   // Full-width sum; the top bit is the carry that bumps the duty by one.
   always_comb begin
      sum_s = {1'b0, acc_r} + {1'b0, lo};
      carry = sum_s[W];
   end

   // Accumulator wraps modulo 2**W; clear has priority over load.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_r <= {W{1'b0}};
      end else if (clear) begin
         acc_r <= {W{1'b0}};
      end else if (load) begin
         acc_r <= sum_s[W-1:0];
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: rtl/red_pitaya_pwm_sd.sv
// Sigma-delta dithered PWM for one slow analog output. An 8-bit PWM period
// carries the 8 MSBs of the offset sample; the 6 LSBs are spread over 64
// periods by a first-order accumulator, giving 14-bit average resolution.
module red_pitaya_pwm_sd
   import red_pitaya_pkg::*;
#(
   parameter int unsigned CCW_BITS    = PWM_CCW_BITS,
   parameter int unsigned DITHER_BITS = PWM_DITHER_BITS
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [PWM_DAT_BITS-1:0]       dat_i,
   input  logic                          en_i,
   output logic                          pwm_o,
   output logic                          period_o,
   output logic [CCW_BITS:0]             duty_o
);

   localparam logic [CCW_BITS-1:0] CNT_MAX = {CCW_BITS{1'b1}};

   logic [CCW_BITS-1:0]     cnt_r;
   logic [CCW_BITS-1:0]     cnt_next_s;
   logic [CCW_BITS:0]       duty_r;
   logic [CCW_BITS:0]       duty_next_s;
   logic                    en_q_r;
   logic                    en_next_s;
   logic                    pwm_r;
   logic                    pwm_next_s;
   logic                    period_r;
   logic                    boundary_s;
   logic [PWM_DAT_BITS-1:0] u_s;
   logic [CCW_BITS-1:0]     hi_s;
   logic [DITHER_BITS-1:0]  lo_s;
   logic                    carry_s;

   assign u_s  = pwm_offset_conv(dat_i);
   assign hi_s = u_s[PWM_DAT_BITS-1:DITHER_BITS];
   assign lo_s = u_s[DITHER_BITS-1:0];

   assign boundary_s = (cnt_r == CNT_MAX);
   assign cnt_next_s = cnt_r + {{(CCW_BITS-1){1'b0}}, 1'b1};

   red_pitaya_pwm_sd_acc #(
      .W (DITHER_BITS)
   ) u_acc (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .lo     (lo_s),
      .load   (boundary_s & en_i),
      .clear  (~en_i),
      .carry  (carry_s)
   );

   // Next enable/duty state: disable acts immediately and wins over a boundary;
   // enable and new data only take effect at a period boundary.
   always_comb begin
      en_next_s   = en_q_r;
      duty_next_s = duty_r;
      if (!en_i) begin
         en_next_s   = 1'b0;
         duty_next_s = {(CCW_BITS+1){1'b0}};
      end else if (boundary_s) begin
         en_next_s   = 1'b1;
         duty_next_s = {1'b0, hi_s} + {{CCW_BITS{1'b0}}, carry_s};
      end else begin
         en_next_s   = en_q_r;
         duty_next_s = duty_r;
      end
      pwm_next_s = en_next_s && ({1'b0, cnt_next_s} < duty_next_s);
   end

   // Period counter, sample registers and registered outputs.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_r    <= {CCW_BITS{1'b0}};
         duty_r   <= {(CCW_BITS+1){1'b0}};
         en_q_r   <= 1'b0;
         pwm_r    <= 1'b0;
         period_r <= 1'b0;
      end else begin
         cnt_r    <= cnt_next_s;
         duty_r   <= duty_next_s;
         en_q_r   <= en_next_s;
         pwm_r    <= pwm_next_s;
         period_r <= (cnt_next_s == CNT_MAX);
      end
   end

   assign pwm_o    = pwm_r;
   assign period_o = period_r;
   assign duty_o   = duty_r;

endmodule

// File: tb/tb_red_pitaya_pwm_sd.sv
// Directed self-checking bench for red_pitaya_pwm_sd: table of data vectors
// checked over 64 dither periods each, plus enable and reset sequences.
module tb_red_pitaya_pwm_sd;
   import red_pitaya_pkg::*;

   logic        clk;
   logic        rstn;
   logic [13:0] dat;
   logic        en;
   logic        pwm;
   logic        period;
   pwm_duty_t   duty;

   int checks   = 0;
   int failures = 0;

   red_pitaya_pwm_sd dut (
      .clk_i    (clk),
      .rstn_i   (rstn),
      .dat_i    (dat),
      .en_i     (en),
      .pwm_o    (pwm),
      .period_o (period),
      .duty_o   (duty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] dat;
      int          d0;
      int          d1;
      int          total;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Advance to the negedge where period_o is high (cnt = max), bounded.
   task automatic wait_period(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period && n < 300);
      if (!period) check({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int hi_cnt;
      int total;
      int d_first;
      int n;

      vecs[0] = '{dat: 14'h2000, d0: 0,   d1: 0,   total: 0};
      vecs[1] = '{dat: 14'h0000, d0: 128, d1: 128, total: 8192};
      vecs[2] = '{dat: 14'h0020, d0: 128, d1: 129, total: 8224};
      vecs[3] = '{dat: 14'h1FFF, d0: 255, d1: 256, total: 16383};

      // Reset state and first boundary after release.
      rstn = 1'b0;
      en   = 1'b0;
      dat  = 14'h0000;
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(pwm), 0);
      check("rst_period", int'(period), 0);
      check("rst_duty", int'(duty), 0);
      rstn = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period && n < 300);
      check("first_period_after_rst", n, 255);

      // Table-driven data vectors, each over 64 periods from acc = 0.
      for (int v = 0; v < 4; v++) begin
         @(negedge clk);
         en  = 1'b0;
         dat = vecs[v].dat;
         @(negedge clk);
         check($sformatf("v%0d_disabled_duty", v), int'(duty), 0);
         en = 1'b1;
         wait_period($sformatf("v%0d_sync", v));
         total = 0;
         for (int p = 0; p < 64; p++) begin
            hi_cnt  = 0;
            d_first = 0;
            for (int k = 0; k < 256; k++) begin
               @(negedge clk);
               if (pwm) hi_cnt++;
               if (k == 0) d_first = int'(duty);
               if (k == 0 || k == 254 || k == 255)
                  check($sformatf("v%0d_p%0d_period_k%0d", v, p, k), int'(period), (k == 255) ? 1 : 0);
               // Mid-period data changes must be ignored.
               if (k == 100) dat = ~vecs[v].dat;
               if (k == 200) dat = vecs[v].dat;
               if (k == 255) check($sformatf("v%0d_p%0d_duty_stable", v, p), int'(duty), d_first);
            end
            check($sformatf("v%0d_p%0d_hi_vs_duty", v, p), hi_cnt, d_first);
            if (p == 0) check($sformatf("v%0d_duty0", v), d_first, vecs[v].d0);
            if (p == 1) check($sformatf("v%0d_duty1", v), d_first, vecs[v].d1);
            total += hi_cnt;
         end
         check($sformatf("v%0d_total_hi", v), total, vecs[v].total);
      end

      // Enable drop at cnt 50, re-raise at cnt 100, dat = 0.
      dat = 14'h0000;
      en  = 1'b1;
      wait_period("en_sync");
      hi_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (k == 0) check("en_duty_before_drop", int'(duty), 128);
         if (k == 50) begin
            check("en_pwm_before_drop", int'(pwm), 1);
            en = 1'b0;
         end
         if (k == 51) begin
            check("en_pwm_after_drop", int'(pwm), 0);
            check("en_duty_after_drop", int'(duty), 0);
         end
         if (k == 100) en = 1'b1;
         if (k >= 51 && pwm) hi_cnt++;
         if (k == 255) check("en_duty_waiting", int'(duty), 0);
      end
      check("en_hi_while_waiting", hi_cnt, 0);
      hi_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (pwm) hi_cnt++;
         if (k == 0) begin
            check("en_pwm_first_cycle", int'(pwm), 1);
            check("en_duty_resumed", int'(duty), 128);
         end
      end
      check("en_hi_resumed", hi_cnt, 128);

      // Asynchronous reset mid-period while pwm is high.
      wait_period("rst_sync");
      for (int k = 0; k < 78; k++) @(negedge clk);
      check("rst77_pwm_before", int'(pwm), 1);
      rstn = 1'b0;
      #1;
      check("rst77_pwm", int'(pwm), 0);
      check("rst77_period", int'(period), 0);
      check("rst77_duty", int'(duty), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period && n < 300);
      check("rst77_first_period", n, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
